// File: rtl/expr_eval_if.sv
// Character stream in, evaluation status out, for the expression evaluator.
interface expr_eval_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic [7:0]                   in;
  logic                         in_valid;
  logic                         out;
  logic [WIDTH-1:0]             value;
  logic                         err;
  logic [$clog2(DEPTH+1)-1:0]   depth;

  // The character source drives in/in_valid and observes the result.
  modport master (
    output in, in_valid,
    input  out, value, err, depth
  );

  // The evaluator consumes characters and reports the result.
  modport slave (
    input  in, in_valid,
    output out, value, err, depth
  );
endinterface

// File: rtl/expr_eval.sv
// Streaming evaluator for '+' / '*' / parenthesised decimal expressions.
// One character is consumed per accepted cycle.
// The running result is kept as S + P*N, so precedence needs no operator stack.
// Only (S,P) is saved across a '(' and restored at the matching ')'.
module expr_eval #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  expr_eval_if.slave  bus
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [DW-1:0]    DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0]    DEP_ONE   = DW'(1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TEN       = WIDTH'(10);

  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_LP   = 8'h28;
  localparam logic [7:0] CH_RP   = 8'h29;

  typedef enum logic [1:0] {OPND, NUM, CLOSE, ERR} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s, p, n;
  logic [DW-1:0]    dep;
  logic [WIDTH-1:0] stack_s [DEPTH];
  logic [WIDTH-1:0] stack_p [DEPTH];

  logic [WIDTH-1:0] prod, cur;
  logic             is_digit, is_op, is_lp, is_rp, at_max, at_zero;
  logic             do_digit, do_mul, do_add, do_push, do_pop;
  logic [IW-1:0]    push_idx, pop_idx;

  assign prod     = p * n;
  assign cur      = s + prod;
  assign is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign is_op    = (bus.in == CH_PLUS) || (bus.in == CH_STAR);
  assign is_lp    = (bus.in == CH_LP);
  assign is_rp    = (bus.in == CH_RP);
  assign at_max   = (dep == DEPTH_MAX);
  assign at_zero  = (dep == '0);
  assign push_idx = IW'(dep);
  assign pop_idx  = IW'(dep - DEP_ONE);

  // State register; a reset always lands in OPND regardless of the character.
  always_ff @(posedge clk) begin
    if (!clr_n) state <= OPND;
    else        state <= state_nxt;
  end

  // Next-state decode plus datapath strobes; any move into ERR raises no strobe so the datapath freezes.
  always_comb begin
    state_nxt = state;
    do_digit  = 1'b0;
    do_mul    = 1'b0;
    do_add    = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    if (bus.in_valid) begin
      unique case (state)
        OPND: begin
          if (is_digit) begin
            state_nxt = NUM;
            do_digit  = 1'b1;
          end else if (is_lp && !at_max) begin
            state_nxt = OPND;
            do_push   = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
        NUM: begin
          if (is_digit) begin
            state_nxt = NUM;
            do_digit  = 1'b1;
          end else if (is_op) begin
            state_nxt = OPND;
            do_mul    = (bus.in == CH_STAR);
            do_add    = (bus.in == CH_PLUS);
          end else if (is_rp && !at_zero) begin
            state_nxt = CLOSE;
            do_pop    = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
        CLOSE: begin
          if (is_op) begin
            state_nxt = OPND;
            do_mul    = (bus.in == CH_STAR);
            do_add    = (bus.in == CH_PLUS);
          end else if (is_rp && !at_zero) begin
            state_nxt = CLOSE;
            do_pop    = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
        default: state_nxt = ERR;
      endcase
    end
  end

  // Sum/product/operand registers and nesting depth, updated by the strobes.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      s   <= '0;
      p   <= ONE;
      n   <= '0;
      dep <= '0;
    end else begin
      if (do_digit) n <= n * TEN + WIDTH'(bus.in[3:0]);
      if (do_mul) begin
        p <= prod;
        n <= '0;
      end
      if (do_add) begin
        s <= cur;
        p <= ONE;
        n <= '0;
      end
      if (do_push) begin
        s   <= '0;
        p   <= ONE;
        n   <= '0;
        dep <= dep + DEP_ONE;
      end
      if (do_pop) begin
        n   <= cur;
        s   <= stack_s[pop_idx];
        p   <= stack_p[pop_idx];
        dep <= dep - DEP_ONE;
      end
    end
  end

  // Save the outer (S,P) on '('; entries above the depth pointer are never read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (clr_n && do_push) begin
      stack_s[push_idx] <= s;
      stack_p[push_idx] <= p;
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    bus.out   = ((state == NUM) || (state == CLOSE)) && at_zero;
    bus.value = cur;
    bus.err   = (state == ERR);
    bus.depth = dep;
  end

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: default build plus a DEPTH=2 and a WIDTH=8 build fed the same stream.
module tb_expr_eval;

  logic       clk;
  logic       clr_n;
  logic [7:0] ch;
  logic       vld;
  int         vectors;
  int         miscompares;

  expr_eval_if #(.WIDTH(32), .DEPTH(4)) if_a ();
  expr_eval_if #(.WIDTH(32), .DEPTH(2)) if_b ();
  expr_eval_if #(.WIDTH(8),  .DEPTH(4)) if_c ();

  assign if_a.in = ch;  assign if_a.in_valid = vld;
  assign if_b.in = ch;  assign if_b.in_valid = vld;
  assign if_c.in = ch;  assign if_c.in_valid = vld;

  expr_eval #(.WIDTH(32), .DEPTH(4)) dut_a (.clk(clk), .clr_n(clr_n), .bus(if_a));
  expr_eval #(.WIDTH(32), .DEPTH(2)) dut_b (.clk(clk), .clr_n(clr_n), .bus(if_b));
  expr_eval #(.WIDTH(8),  .DEPTH(4)) dut_c (.clk(clk), .clr_n(clr_n), .bus(if_c));

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one character for exactly one rising edge, then sample 1 time unit later.
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    ch  = c;
    vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  // Feed a string one character per cycle.
  task automatic applyStimulus(input string str);
    for (int i = 0; i < str.len(); i++) send(str[i]);
  endtask

  // One reset cycle with a valid digit presented, which must not be accepted.
  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    ch    = "7";
    vld   = 1'b1;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    vld   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (if_a.out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out: got %0b expected 0", if_a.out); end
    vectors++; if (if_a.err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %0b expected 0", if_a.err); end
    vectors++; if (if_a.value !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_value: got %0d expected 0", if_a.value); end
    vectors++; if (if_a.depth !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_depth: got %0d expected 0", if_a.depth); end
  endtask

  task automatic test_precedence();
    do_reset();
    applyStimulus("1+2*3");
    vectors++; if (if_a.out !== 1'b1) begin miscompares++; $display("[TB] FAIL prec_out: got %0b expected 1", if_a.out); end
    vectors++; if (if_a.value !== 32'd7) begin miscompares++; $display("[TB] FAIL prec_value: got %0d expected 7", if_a.value); end
    do_reset();
    applyStimulus("12*10+5");
    vectors++; if (if_a.value !== 32'd125) begin miscompares++; $display("[TB] FAIL multidigit_value: got %0d expected 125", if_a.value); end
    do_reset();
    applyStimulus("007*3");
    vectors++; if (if_a.value !== 32'd21) begin miscompares++; $display("[TB] FAIL leadzero_value: got %0d expected 21", if_a.value); end
  endtask

  task automatic test_parens();
    do_reset();
    applyStimulus("(12+3");
    vectors++; if (if_a.out !== 1'b0) begin miscompares++; $display("[TB] FAIL paren_open_out: got %0b expected 0", if_a.out); end
    vectors++; if (if_a.depth !== 3'd1) begin miscompares++; $display("[TB] FAIL paren_open_depth: got %0d expected 1", if_a.depth); end
    applyStimulus(")");
    vectors++; if (if_a.out !== 1'b1) begin miscompares++; $display("[TB] FAIL paren_close_out: got %0b expected 1", if_a.out); end
    vectors++; if (if_a.value !== 32'd15) begin miscompares++; $display("[TB] FAIL paren_close_value: got %0d expected 15", if_a.value); end
    applyStimulus("*4");
    vectors++; if (if_a.value !== 32'd60) begin miscompares++; $display("[TB] FAIL paren_mul_value: got %0d expected 60", if_a.value); end
  endtask

  task automatic test_error_sticky();
    do_reset();
    applyStimulus("1+");
    vectors++; if (if_a.err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_before: got %0b expected 0", if_a.err); end
    applyStimulus("+");
    vectors++; if (if_a.err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_set: got %0b expected 1", if_a.err); end
    applyStimulus("2");
    vectors++; if (if_a.err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_sticky: got %0b expected 1", if_a.err); end
    vectors++; if (if_a.out !== 1'b0) begin miscompares++; $display("[TB] FAIL err_out: got %0b expected 0", if_a.out); end
    vectors++; if (if_a.value !== 32'd1) begin miscompares++; $display("[TB] FAIL err_frozen_value: got %0d expected 1", if_a.value); end
    do_reset();
    vectors++; if (if_a.err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_cleared: got %0b expected 0", if_a.err); end
    vectors++; if (if_a.out !== 1'b0) begin miscompares++; $display("[TB] FAIL err_reset_out: got %0b expected 0", if_a.out); end
    applyStimulus("5");
    vectors++; if (if_a.out !== 1'b1) begin miscompares++; $display("[TB] FAIL err_recover_out: got %0b expected 1", if_a.out); end
    vectors++; if (if_a.value !== 32'd5) begin miscompares++; $display("[TB] FAIL err_recover_value: got %0d expected 5", if_a.value); end
  endtask

  task automatic test_illegal_close();
    do_reset();
    applyStimulus(")");
    vectors++; if (if_a.err !== 1'b1) begin miscompares++; $display("[TB] FAIL close_at_start: got %0b expected 1", if_a.err); end
    do_reset();
    applyStimulus("(1)");
    vectors++; if (if_a.err !== 1'b0) begin miscompares++; $display("[TB] FAIL close_ok_err: got %0b expected 0", if_a.err); end
    vectors++; if (if_a.value !== 32'd1) begin miscompares++; $display("[TB] FAIL close_ok_value: got %0d expected 1", if_a.value); end
    applyStimulus("2");
    vectors++; if (if_a.err !== 1'b1) begin miscompares++; $display("[TB] FAIL digit_after_close: got %0b expected 1", if_a.err); end
  endtask

  task automatic test_depth_limit();
    do_reset();
    applyStimulus("((");
    vectors++; if (if_b.err !== 1'b0) begin miscompares++; $display("[TB] FAIL depth2_err: got %0b expected 0", if_b.err); end
    vectors++; if (if_b.depth !== 2'd2) begin miscompares++; $display("[TB] FAIL depth2_depth: got %0d expected 2", if_b.depth); end
    applyStimulus("(");
    vectors++; if (if_b.err !== 1'b1) begin miscompares++; $display("[TB] FAIL depth_over_err: got %0b expected 1", if_b.err); end
    vectors++; if (if_b.depth !== 2'd2) begin miscompares++; $display("[TB] FAIL depth_over_depth: got %0d expected 2", if_b.depth); end
  endtask

  task automatic test_wrap();
    do_reset();
    applyStimulus("16*16+3");
    vectors++; if (if_c.out !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_out: got %0b expected 1", if_c.out); end
    vectors++; if (if_c.value !== 8'd3) begin miscompares++; $display("[TB] FAIL wrap_value: got %0d expected 3", if_c.value); end
  endtask

  task automatic test_gaps();
    do_reset();
    applyStimulus("7");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ch  = "+";
      vld = 1'b0;
      @(posedge clk);
      #1;
      vectors++; if (if_a.out !== 1'b1) begin miscompares++; $display("[TB] FAIL gap_out[%0d]: got %0b expected 1", k, if_a.out); end
      vectors++; if (if_a.value !== 32'd7) begin miscompares++; $display("[TB] FAIL gap_value[%0d]: got %0d expected 7", k, if_a.value); end
    end
    applyStimulus("*2");
    vectors++; if (if_a.value !== 32'd14) begin miscompares++; $display("[TB] FAIL gap_resume_value: got %0d expected 14", if_a.value); end
  endtask

  task automatic test_back_to_back();
    // 2*(3+(4*5))+1 = 2*23+1 = 47, reaching depth 2 midway
    do_reset();
    applyStimulus("2*(3+(4*5");
    vectors++; if (if_a.depth !== 3'd2) begin miscompares++; $display("[TB] FAIL nest_depth: got %0d expected 2", if_a.depth); end
    applyStimulus("))+1");
    vectors++; if (if_a.out !== 1'b1) begin miscompares++; $display("[TB] FAIL nest_out: got %0b expected 1", if_a.out); end
    vectors++; if (if_a.value !== 32'd47) begin miscompares++; $display("[TB] FAIL nest_value: got %0d expected 47", if_a.value); end
  endtask

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence and final summary.
  initial begin
    vectors     = 0;
    miscompares = 0;
    clr_n       = 1'b1;
    ch          = 8'h00;
    vld         = 1'b0;
    test_reset();
    test_precedence();
    test_parens();
    test_error_sticky();
    test_illegal_close();
    test_depth_limit();
    test_wrap();
    test_gaps();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/expr_eval.md
EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 Parameter WIDTH, default 32: width of the arithmetic result; all arithmetic is modulo 2^WIDTH.
REQ-002 Parameter DEPTH, default 4: maximum parenthesis nesting depth, at least 1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr_n  input  1  synchronous active-low reset.
REQ-005 in  input  8  ASCII character.
REQ-006 in_valid  input  1  qualifies in; character accepted on rising edge when high.
REQ-007 out  output  1  accepted string is a complete, well-formed expression.
REQ-008 value  output  WIDTH  current evaluation result; defined only while out=1.
REQ-009 err  output  1  sticky syntax-error flag.
REQ-010 depth  output  $clog2(DEPTH+1)  current open-parenthesis count.

Function
REQ-011 Grammar: expr := term ('+' term)*; term := factor ('*' factor)*; factor := number | '(' expr ')'; number := one or more of '0'..'9'; leading zeros legal.
REQ-012 FSM states: OPND (operand expected; after reset, operator or '('), NUM (after digit), CLOSE (after ')'), ERR.
REQ-013 OPND: digit -> NUM; '(' -> OPND with push; anything else -> ERR.
REQ-014 NUM: digit -> NUM; '+' or '*' -> OPND; ')' with depth>0 -> CLOSE with pop; other -> ERR.
REQ-015 CLOSE: '+' or '*' -> OPND; ')' with depth>0 -> CLOSE with pop; digit, '(' or other -> ERR.
REQ-016 ')' at depth=0 -> ERR; '(' at depth=DEPTH -> ERR, stack unchanged.
REQ-017 ERR is absorbing until reset; further characters ignored.
REQ-018 Datapath registers S (sum), P (product), N (operand), each WIDTH bits; value = S + P*N, truncated to WIDTH.
REQ-019 Digit d: N <= N*10 + d. '*': P <= P*N, N <= 0. '+': S <= S + P*N, P <= 1, N <= 0.
REQ-020 '(': push (S,P) onto a DEPTH-entry stack; S <= 0, P <= 1, N <= 0; depth increments.
REQ-021 ')': N <= S + P*N of the inner level; pop (S,P); depth decrements.
REQ-022 Overflow wraps silently; there is no overflow flag.
REQ-023 out = 1 iff state is NUM or CLOSE and depth = 0; otherwise out = 0.
REQ-024 Latency: one cycle.
  - out, value, err and depth reflect every character accepted up to and including the most recent edge.
  - All four outputs derive from registered state only.
REQ-025 in_valid=0: all state held; in is ignored.
REQ-026 err = 1 iff state = ERR.
REQ-027 On the cycle a character causes ERR:
  - S, P, N and the stack freeze at their prior values.
  - out is forced to 0.

Reset
REQ-028 clr_n=0 at a rising edge returns the block to its reset state, regardless of in_valid and current state.
  - Reset state: OPND, S=0, P=1, N=0, depth=0.
  - Reset outputs: out=0, err=0, value=0.
REQ-029 Reset mid-expression or from ERR discards all partial state and stack contents.
REQ-030 The character presented in the reset cycle is not accepted.

Verification
REQ-031 Precedence and multi-digit numbers:
  - Reset, then "1","+","2","*","3" on consecutive cycles -> out=1, value=7 after the last edge.
  - Same bench, "12*10+5" -> value=125.
REQ-032 Parentheses and depth:
  - "(12+3)*4" -> after "(12+3": out=0, depth=1; after ")": out=1, value=15; after "*4": value=60.
REQ-033 Error sticks, reset clears:
  - "1++" -> err=1 after the second '+'; "2" -> err stays 1, out=0.
  - One cycle clr_n=0 -> out=0, err=0.
  - Then "5" -> out=1, value=5.
REQ-034 Illegal closes:
  - ")" at start -> err=1.
  - "(1)2" -> err=1 on the '2'.
  - With DEPTH=2, "(((" -> err=1 on the third '(', depth=2.
REQ-035 Wrap-around: WIDTH=8, "16*16+3" -> out=1, value=3.
REQ-036 Qualifier gaps:
  - "7" accepted, then 5 cycles of in_valid=0 with in="+" -> outputs unchanged (out=1, value=7).
  - Then "*2" with in_valid=1 -> value=14.
